// File: rtl/nand_reduce_pkg.sv
// Shared mode encodings and mode-decode helpers for the reduction pipeline.
package nand_reduce_pkg;

    localparam logic [1:0] MODE_NAND = 2'b00;
    localparam logic [1:0] MODE_AND  = 2'b01;
    localparam logic [1:0] MODE_NOR  = 2'b10;
    localparam logic [1:0] MODE_OR   = 2'b11;

    // OR-type modes reduce with OR; AND-type modes reduce with AND.
    function automatic logic is_or_type(input logic [1:0] mode);
        return mode[1];
    endfunction

    // NAND and NOR invert the raw reduction.
    function automatic logic invert(input logic [1:0] mode);
        return ~mode[0];
    endfunction

endpackage

// File: rtl/nand_reduce_slice.sv
// One elastic register slice: holds {valid, data}.
// It loads whenever it is empty or its downstream neighbour is taking its beat.
module nand_reduce_slice #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             down_ready
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             load;

    assign load     = !valid_reg || down_ready;
    assign up_ready = load;
    assign valid    = valid_reg;
    assign data     = data_reg;

    // Slice register: data only changes when a real beat is captured, so a
    // bubble passing through does not disturb the held value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= up_valid;
            if (up_valid) begin
                data_reg <= up_data;
            end
        end
    end

endmodule

// File: rtl/nand_reduce_pipe.sv
// Masked N-input bitwise NAND/AND/NOR/OR reduction followed by a chain of
// elastic register slices. Ready ripples combinationally from out_ready back
// to in_ready, so a full pipeline can accept and drain in the same cycle.
module nand_reduce_pipe
    import nand_reduce_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NIN    = 3,
    parameter int STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [NIN-1:0]       in_mask,
    input  logic [1:0]           in_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    logic             or_type;
    logic [WIDTH-1:0] chan_term [NIN];
    logic [WIDTH-1:0] reduced;
    logic [WIDTH-1:0] result;
    logic [STAGES-1:0] valid_vec;

    assign or_type = is_or_type(in_mode);

    // A masked channel is replaced by the identity of the reduction operator
    // (all ones for AND, all zeros for OR) so it cannot affect the result.
    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_chan
            assign chan_term[gi] = in_mask[gi] ? in_data[gi*WIDTH +: WIDTH]
                                               : {WIDTH{~or_type}};
        end
    endgenerate

    // Reduce all channel terms, then apply the optional output inversion.
    always_comb begin
        reduced = {WIDTH{~or_type}};
        for (int k = 0; k < NIN; k++) begin
            reduced = or_type ? (reduced | chan_term[k]) : (reduced & chan_term[k]);
        end
        result = invert(in_mode) ? ~reduced : reduced;
    end

    // Slice chain: each slice's upstream is its predecessor, its downstream
    // ready is its successor's load (or out_ready for the last one).
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             up_valid;
            logic [WIDTH-1:0] up_data;
            logic             up_ready;
            logic             down_ready;
            logic             valid;
            logic [WIDTH-1:0] data;

            if (gi == 0) begin : g_first
                assign up_valid = in_valid;
                assign up_data  = result;
            end else begin : g_mid
                assign up_valid = g_stage[gi-1].valid;
                assign up_data  = g_stage[gi-1].data;
            end

            if (gi == STAGES - 1) begin : g_last
                assign down_ready = out_ready;
            end else begin : g_inner
                assign down_ready = g_stage[gi+1].up_ready;
            end

            nand_reduce_slice #(
                .WIDTH(WIDTH)
            ) u_slice (
                .CLK       (CLK),
                .RST_N     (RST_N),
                .up_valid  (up_valid),
                .up_data   (up_data),
                .up_ready  (up_ready),
                .valid     (valid),
                .data      (data),
                .down_ready(down_ready)
            );

            assign valid_vec[gi] = valid;
        end
    endgenerate

    assign in_ready  = g_stage[0].up_ready;
    assign out_valid = g_stage[STAGES-1].valid;
    assign out_data  = g_stage[STAGES-1].data;
    assign busy      = |valid_vec;

endmodule
